// File: rtl/load_pkg.sv
// ============================================================================
// Module   : load_pkg
// Purpose  : Shared definitions for the byte-serial load sequencer.
//            Defines the access-size encodings, the controller state encoding
//            and the helper that maps an access size to its byte count.
// Contents : size_e    - SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD
//            state_e   - ST_IDLE / ST_READ / ST_FINISH
//            byte_count(size_e) -> number of memory byte reads (0 = none)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;   // counts 0..4 bytes

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  // Number of byte reads needed for an access; the reserved size reads nothing.
  function automatic logic [CNT_W-1:0] byte_count(input size_e sz);
    case (sz)
      SZ_BYTE: byte_count = 3'd1;
      SZ_HALF: byte_count = 3'd2;
      SZ_WORD: byte_count = 3'd4;
      default: byte_count = 3'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sign_extend_unit.sv
// ============================================================================
// Module   : sign_extend_unit
// Purpose  : Combinational extender for assembled load data. Byte and half
//            results are sign- or zero-extended to 32 bits; word results pass
//            through untouched (the signed flag has no effect on them).
// Ports    : data_i   [31:0] assembled little-endian load data
//            size_i   [1:0]  access size (size_e)
//            signed_i        1 = sign-extend, 0 = zero-extend
//            data_o   [31:0] extended result
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sign_extend_unit
  import load_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  size_e             size_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] data_o
);

  logic w_fill8;
  logic w_fill16;

  // Replicated fill bit: the source sign bit when signed, otherwise zero.
  assign w_fill8  = signed_i & data_i[7];
  assign w_fill16 = signed_i & data_i[15];

  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{w_fill8}}, data_i[7:0]};
      SZ_HALF: data_o = {{16{w_fill16}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_byte_sequencer.sv
// ============================================================================
// Module   : load_byte_sequencer
// Purpose  : Multi-cycle load controller for a byte-wide data memory. Accepts
//            a byte/half/word load, issues one byte read per MemReq/MemAck
//            handshake (little-endian, lowest address first), assembles the
//            bytes, extends the result and reports it with a one-cycle Done.
// Ports    : Clk, Rst_n            clock, asynchronous active-low reset
//            Start/Addr/Size/Signed load request (accepted only when idle)
//            Busy, Done, Err, Y    status and extended result
//            MemReq/MemAddr        byte read request and address
//            MemRdata/MemAck       read byte and completion handshake
// Config   : LOAD_ALIGN_CHECK_EN - when defined, misaligned half/word loads
//            complete immediately with Err=1 and no memory access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_byte_sequencer
  import load_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [1:0]        Size,
  input  logic              Signed,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [DATA_W-1:0] Y,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [7:0]        MemRdata,
  input  logic              MemAck
);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e              state_q,   state_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  size_e               size_q,    size_d;
  logic                sign_q,    sign_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [DATA_W-1:0]   asm_q,     asm_d;

  // Registered outputs
  logic                busy_q;
  logic                done_q;
  logic                err_q,     err_d;
  logic [DATA_W-1:0]   y_q,       y_d;
  logic                memreq_q;
  logic [ADDR_W-1:0]   memaddr_q, memaddr_d;

  // Combinational helpers
  logic [DATA_W-1:0]   w_asm_ins;   // assembly register with the current byte merged in
  logic [DATA_W-1:0]   w_ext;       // extended form of w_asm_ins
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_last;
  logic                w_misalign;
  logic                w_bad_size;

  // --------------------------------------------------------------------------
  // Request classification
  // --------------------------------------------------------------------------
  assign w_bad_size = (size_e'(Size) == SZ_RSVD);

`ifdef LOAD_ALIGN_CHECK_EN
  assign w_misalign = ((size_e'(Size) == SZ_HALF) && Addr[0]) ||
                      ((size_e'(Size) == SZ_WORD) && (Addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Byte assembly: the incoming byte lands in lane [cnt_q]. Computed apart from
  // the FSM so the extender sees only registers and inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    w_asm_ins = asm_q;
    case (cnt_q[1:0])
      2'd0:    w_asm_ins[7:0]   = MemRdata;
      2'd1:    w_asm_ins[15:8]  = MemRdata;
      2'd2:    w_asm_ins[23:16] = MemRdata;
      default: w_asm_ins[31:24] = MemRdata;
    endcase
  end

  assign w_cnt_inc = cnt_q + 3'd1;
  assign w_last    = (w_cnt_inc == byte_count(size_q));

  // Extension happens on the READ->FINISH transition so Y is already
  // registered and valid in the Done cycle.
  sign_extend_unit u_sign_extend (
    .data_i   (w_asm_ins),
    .size_i   (size_q),
    .signed_i (sign_q),
    .data_o   (w_ext)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    y_d     = y_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          addr_d = Addr;
          size_d = size_e'(Size);
          sign_d = Signed;
          cnt_d  = '0;
          asm_d  = '0;
          if (w_bad_size || w_misalign) begin
            // Rejected requests finish straight away without touching memory.
            state_d = ST_FINISH;
            err_d   = 1'b1;
            y_d     = '0;
          end else begin
            state_d = ST_READ;
          end
        end
      end

      ST_READ: begin
        if (MemAck) begin
          asm_d = w_asm_ins;
          cnt_d = w_cnt_inc;
          if (w_last) begin
            state_d = ST_FINISH;
            y_d     = w_ext;
          end
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // MemAddr tracks the byte that will be requested in the next cycle; it is
  // only updated on an accepted byte, so it stays put during wait cycles.
  // The add wraps naturally at ADDR_W bits.
  assign memaddr_d = (state_d == ST_READ) ? (addr_d + ADDR_W'(cnt_d)) : memaddr_q;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_q    <= '0;
      size_q    <= SZ_BYTE;
      sign_q    <= 1'b0;
      cnt_q     <= '0;
      asm_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      y_q       <= '0;
      memreq_q  <= 1'b0;
      memaddr_q <= '0;
    end else begin
      addr_q    <= addr_d;
      size_q    <= size_d;
      sign_q    <= sign_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_FINISH);
      err_q     <= err_d;
      y_q       <= y_d;
      memreq_q  <= (state_d == ST_READ);
      memaddr_q <= memaddr_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign Y       = y_q;
  assign MemReq  = memreq_q;
  assign MemAddr = memaddr_q;

endmodule

`default_nettype wire

// File: tb/tb_load_byte_sequencer.sv
`default_nettype none

module tb_load_byte_sequencer;

  localparam int unsigned ADDR_W = 32;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic              Start;
  logic [ADDR_W-1:0] Addr;
  logic [1:0]        Size;
  logic              Signed;
  logic              Busy;
  logic              Done;
  logic              Err;
  logic [31:0]       Y;
  logic              MemReq;
  logic [ADDR_W-1:0] MemAddr;
  logic [7:0]        MemRdata;
  logic              MemAck;

  load_byte_sequencer #(.ADDR_W(ADDR_W)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .Addr     (Addr),
    .Size     (Size),
    .Signed   (Signed),
    .Busy     (Busy),
    .Done     (Done),
    .Err      (Err),
    .Y        (Y),
    .MemReq   (MemReq),
    .MemAddr  (MemAddr),
    .MemRdata (MemRdata),
    .MemAck   (MemAck)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] y;
    logic        err;
    int unsigned done_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  data_q[$];
  logic [31:0] addr_q[$];
  int unsigned mem_wait    = 0;
  int unsigned req_cycles  = 0;
  int unsigned n_checks    = 0;
  int unsigned n_fail      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory model: answers each byte request after mem_wait wait cycles,
  // serving bytes and checking addresses in the order they were queued.
  initial begin : mem_model
    int unsigned wc;
    logic        req_seen;
    logic [31:0] held;
    wc = 0; req_seen = 1'b0; held = '0;
    MemAck = 1'b0; MemRdata = 8'h00;
    forever begin
      @(posedge Clk); #1;
      if (MemReq === 1'b1) begin
        req_cycles++;
        if (MemAck || !req_seen) wc = 0;
        else                     wc = wc + 1;
        req_seen = 1'b1;
        if (wc == 0) held = MemAddr;
        else         check_eq("memaddr_stable", MemAddr, held);
        MemAck = (wc == mem_wait);
        if (MemAck) begin
          if (addr_q.size() == 0) check_eq("memaddr_extra_req", {31'd0, MemReq}, 32'd0);
          else                    check_eq("MemAddr", MemAddr, addr_q.pop_front());
          MemRdata = (data_q.size() != 0) ? data_q.pop_front() : 8'h00;
        end
      end else begin
        req_seen = 1'b0;
        wc       = 0;
        MemAck   = 1'b0;
      end
    end
  end

  // Scoreboard consumer: every Done pops one expected completion.
  initial begin : done_monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_done", {31'd0, Done}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("Y", Y, e.y);
          check_eq("Err", {31'd0, Err}, {31'd0, e.err});
          check_eq("done_cycle", cyc, e.done_cyc);
          check_eq("busy_at_done", {31'd0, Busy}, 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // Queue n memory bytes (little-endian from `bytes`) at consecutive addresses.
  task automatic load_mem(input logic [31:0] a, input int n, input logic [31:0] bytes);
    for (int i = 0; i < n; i++) begin
      addr_q.push_back(a + i);
      data_q.push_back(bytes[8*i +: 8]);
    end
  endtask

  task automatic wait_idle(input int unsigned bound);
    int unsigned n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge Clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check_eq("done_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  // Issue one load; lat = expected Done cycle relative to the Start edge,
  // nreq = expected number of cycles with MemReq high. poke drives an
  // extra Start in cycle 2 which the busy controller must ignore.
  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic sg,
                       input logic [31:0] ey, input logic ee,
                       input int unsigned lat, input int unsigned nreq, input bit poke);
    exp_t        e;
    int unsigned r0;
    @(posedge Clk); #1;
    r0 = req_cycles;
    e.y = ey; e.err = ee; e.done_cyc = cyc + lat;
    sb_q.push_back(e);
    Start = 1'b1; Size = sz; Addr = a; Signed = sg;
    @(posedge Clk); #1;
    Start = 1'b0; Size = 2'($urandom); Addr = $urandom; Signed = 1'($urandom);
    if (poke) begin
      @(posedge Clk); #1;
      Start = 1'b1; Size = 2'b00; Addr = 32'h0000_0500; Signed = 1'b0;
      @(posedge Clk); #1;
      Start = 1'b0;
    end
    wait_idle(200);
    @(posedge Clk); #2;
    check_eq("req_cycles", req_cycles - r0, nreq);
  endtask

  initial begin : stimulus
    Rst_n = 1'b0; Start = 1'b0; Addr = '0; Size = 2'b00; Signed = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    check_eq("rst_Busy",    {31'd0, Busy},   32'd0);
    check_eq("rst_Done",    {31'd0, Done},   32'd0);
    check_eq("rst_Err",     {31'd0, Err},    32'd0);
    check_eq("rst_MemReq",  {31'd0, MemReq}, 32'd0);
    check_eq("rst_MemAddr", MemAddr,         32'd0);
    check_eq("rst_Y",       Y,               32'd0);
    @(negedge Clk); Rst_n = 1'b1;

    // Byte, signed, zero-wait
    mem_wait = 0; load_mem(32'h100, 1, 32'h0000_0080);
    issue(2'b00, 32'h100, 1'b1, 32'hFFFF_FF80, 1'b0, 2, 1, 1'b0);

    // Half, unsigned, two wait cycles per byte
    mem_wait = 2; load_mem(32'h200, 2, 32'h0000_F234);
    issue(2'b01, 32'h200, 1'b0, 32'h0000_F234, 1'b0, 7, 6, 1'b0);

    // Word, zero-wait, with an ignored Start in cycle 2
    mem_wait = 0; load_mem(32'h300, 4, 32'h4433_2211);
    issue(2'b10, 32'h300, 1'b1, 32'h4433_2211, 1'b0, 5, 4, 1'b1);

    // Reserved size: immediate error, no memory traffic
    issue(2'b11, 32'h123, 1'b1, 32'h0000_0000, 1'b1, 1, 0, 1'b0);

`ifdef LOAD_ALIGN_CHECK_EN
    load_mem(32'h100, 4, 32'h5555_5555);   // rebuild a nonzero Y first
    issue(2'b10, 32'h100, 1'b0, 32'h5555_5555, 1'b0, 5, 4, 1'b0);
    issue(2'b10, 32'h302, 1'b0, 32'h0000_0000, 1'b1, 1, 0, 1'b0);
    issue(2'b01, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1, 0, 1'b0);
`else
    load_mem(32'h302, 4, 32'hDDCC_BBAA);
    issue(2'b10, 32'h302, 1'b0, 32'hDDCC_BBAA, 1'b0, 5, 4, 1'b0);
    load_mem(32'hFFFF_FFFF, 2, 32'h0000_85AA);
    issue(2'b01, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_85AA, 1'b0, 3, 2, 1'b0);
`endif

    // Byte, unsigned, high bit set, one wait cycle
    mem_wait = 1; load_mem(32'h40, 1, 32'h0000_00F0);
    issue(2'b00, 32'h40, 1'b0, 32'h0000_00F0, 1'b0, 3, 2, 1'b0);

    // Half, signed, positive value
    mem_wait = 0; load_mem(32'h10, 2, 32'h0000_7F01);
    issue(2'b01, 32'h10, 1'b1, 32'h0000_7F01, 1'b0, 3, 2, 1'b0);

    // Word with Signed=1: no extension applies
    load_mem(32'h20, 4, 32'h8000_0000);
    issue(2'b10, 32'h20, 1'b1, 32'h8000_0000, 1'b0, 5, 4, 1'b0);

    repeat (3) @(posedge Clk);
    #2;
    check_eq("Y_hold", Y, 32'h8000_0000);

    // Reset during the third byte of a word load
    mem_wait = 3; load_mem(32'h400, 2, 32'h0000_BBAA);
    @(posedge Clk); #1;
    Start = 1'b1; Size = 2'b10; Addr = 32'h400; Signed = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (8) @(posedge Clk);
    #2;
    check_eq("pre_rst_MemReq", {31'd0, MemReq}, 32'd1);
    Rst_n = 1'b0;
    #1;
    check_eq("mid_rst_MemReq", {31'd0, MemReq}, 32'd0);
    check_eq("mid_rst_Busy",   {31'd0, Busy},   32'd0);
    check_eq("mid_rst_Y",      Y,               32'd0);
    check_eq("mid_rst_bytes_served", addr_q.size(), 0);
    addr_q.delete(); data_q.delete();
    @(negedge Clk); Rst_n = 1'b1;
    repeat (4) @(posedge Clk);
    #2;
    check_eq("post_rst_Busy", {31'd0, Busy}, 32'd0);

    // New byte load after reset
    mem_wait = 0; load_mem(32'h600, 1, 32'h0000_007F);
    issue(2'b00, 32'h600, 1'b1, 32'h0000_007F, 1'b0, 2, 1, 1'b0);

    repeat (3) @(posedge Clk);
    check_eq("sb_empty", sb_q.size(), 0);
    check_eq("mem_queue_empty", addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
